// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencing controller.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      StBoot      = 2'd0,
      StRun       = 2'd1,
      StRedirPend = 2'd2,
      StHalt      = 2'd3
   } state_e;

   localparam logic [4:0]  REG_X0 = 5'd0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds either ID source register.
module hazard_detect
   import fetch_ctrl_pkg::*;
(
   input  logic       ex_mem_rd,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       load_use
);

   // x0 is never a real dependency
   assign load_use = ex_mem_rd && (ex_rd != REG_X0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates redirects, load-use stalls, IMEM wait and halt,
// producing PC and IF/ID control plus stall/flush performance counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             halt_i,
   input  logic             resume_i,
   input  logic             ex_br_taken_i,
   input  logic [31:0]      ex_br_target_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_rd_i,
   input  logic             imem_ready_i,
   output logic             pc_sel_o,
   output logic [31:0]      pc_imm_o,
   output logic             pc_en_o,
   output logic             if_stall_en_o,
   output logic             if_rst_n_o,
   output logic             id_flush_n_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [1:0]       state_o
);

   localparam int unsigned      BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BW-1:0]    BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_e             state_q, state_d;
   logic [BW-1:0]      boot_q;
   logic [31:0]        pend_q, pend_d;
   logic [CNT_W-1:0]   stall_q, flush_q;
   logic               stall_inc, flush_inc;
   logic               load_use;

   hazard_detect u_hazard_detect (
      .ex_mem_rd (ex_mem_rd_i),
      .ex_rd     (ex_rd_i),
      .id_rs1    (id_rs1_i),
      .id_rs2    (id_rs2_i),
      .load_use  (load_use)
   );

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pc_sel_o      = 1'b0;
      pc_imm_o      = pend_q;
      pc_en_o       = 1'b0;
      if_stall_en_o = 1'b0;
      if_rst_n_o    = 1'b0;
      id_flush_n_o  = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      unique case (state_q)
         StBoot: begin
            if (boot_q == BOOT_LAST) state_d = StRun;
         end
         StRun: begin
            pc_en_o       = 1'b1;
            if_stall_en_o = 1'b1;
            if_rst_n_o    = 1'b1;
            id_flush_n_o  = 1'b1;
            if (halt_i) begin
               pc_en_o       = 1'b0;
               if_stall_en_o = 1'b0;
               if_rst_n_o    = 1'b0;
               id_flush_n_o  = 1'b0;
               stall_inc     = 1'b1;
               state_d       = StHalt;
            end else if (ex_br_taken_i && imem_ready_i) begin
               pc_sel_o     = 1'b1;
               pc_imm_o     = ex_br_target_i;
               if_rst_n_o   = 1'b0;
               id_flush_n_o = 1'b0;
               flush_inc    = 1'b1;
            end else if (ex_br_taken_i) begin
               pend_d       = ex_br_target_i;
               pc_en_o      = 1'b0;
               if_rst_n_o   = 1'b0;
               id_flush_n_o = 1'b0;
               stall_inc    = 1'b1;
               state_d      = StRedirPend;
            end else if (load_use || !imem_ready_i) begin
               // Load-use resolves in one cycle because EX receives the bubble
               pc_en_o       = 1'b0;
               if_stall_en_o = 1'b0;
               id_flush_n_o  = 1'b0;
               stall_inc     = 1'b1;
            end
         end
         StRedirPend: begin
            if_stall_en_o = 1'b1;
            if (ex_br_taken_i) pend_d = ex_br_target_i;
            if (imem_ready_i) begin
               pc_sel_o  = 1'b1;
               pc_imm_o  = pend_q;
               pc_en_o   = 1'b1;
               flush_inc = 1'b1;
               state_d   = StRun;
            end
         end
         StHalt: begin
            if_rst_n_o = 1'b1;
            if (resume_i) state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StBoot;
         boot_q  <= '0;
         pend_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (state_q == StBoot) boot_q <= boot_q + 1'b1;
         if (stall_inc && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
         if (flush_inc && (flush_q != CNT_MAX)) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table through a scoreboard queue,
// plus asynchronous mid-redirect reset and counter saturation sequences.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   typedef struct {
      logic        halt, resume, br;
      logic [31:0] tgt;
      logic [4:0]  rs1, rs2, rd;
      logic        memrd, rdy;
      logic [4:0]  out;   // {pc_sel, pc_en, if_stall_en, if_rst_n, id_flush_n}
      logic [4:0]  mask;
      logic [1:0]  st;
      logic        chk_imm;
      logic [31:0] imm;
      int          sc, fc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halt = 1'b0, resume = 1'b0, br = 1'b0, memrd = 1'b0, rdy = 1'b1;
   logic [31:0] tgt = '0;
   logic [4:0]  rs1 = 5'd1, rs2 = 5'd2, rd = 5'd0;
   logic        pc_sel, pc_en, stall_en, if_rst_n, flush_n;
   logic [31:0] pc_imm, stall_cnt, flush_cnt;
   logic [1:0]  state;
   logic        pc_sel2, pc_en2, stall_en2, if_rst_n2, flush_n2;
   logic [31:0] pc_imm2;
   logic [1:0]  stall_cnt2, flush_cnt2, state2;

   int   errors = 0;
   int   checks = 0;
   vec_t exp_q[$];
   vec_t vt[26];

   always #5 clk = ~clk;

   fetch_ctrl #(.BOOT_CYCLES(4), .CNT_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .resume_i(resume),
      .ex_br_taken_i(br), .ex_br_target_i(tgt), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .ex_rd_i(rd), .ex_mem_rd_i(memrd), .imem_ready_i(rdy),
      .pc_sel_o(pc_sel), .pc_imm_o(pc_imm), .pc_en_o(pc_en), .if_stall_en_o(stall_en),
      .if_rst_n_o(if_rst_n), .id_flush_n_o(flush_n), .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt), .state_o(state)
   );

   fetch_ctrl #(.BOOT_CYCLES(1), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .resume_i(resume),
      .ex_br_taken_i(br), .ex_br_target_i(tgt), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .ex_rd_i(rd), .ex_mem_rd_i(memrd), .imem_ready_i(rdy),
      .pc_sel_o(pc_sel2), .pc_imm_o(pc_imm2), .pc_en_o(pc_en2), .if_stall_en_o(stall_en2),
      .if_rst_n_o(if_rst_n2), .id_flush_n_o(flush_n2), .stall_cnt_o(stall_cnt2),
      .flush_cnt_o(flush_cnt2), .state_o(state2)
   );

   function automatic vec_t mk(input logic h, r, b, input logic [31:0] t,
                               input logic [4:0] s1, s2, d, input logic m, y,
                               input logic [4:0] o, mk_mask, input logic [1:0] st,
                               input logic ci, input logic [31:0] im, input int sc, fc);
      vec_t v;
      v.halt = h; v.resume = r; v.br = b; v.tgt = t; v.rs1 = s1; v.rs2 = s2; v.rd = d;
      v.memrd = m; v.rdy = y; v.out = o; v.mask = mk_mask; v.st = st; v.chk_imm = ci;
      v.imm = im; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   task automatic check_vec(input int idx, input vec_t e);
      logic [4:0] act;
      logic       ok;
      act = {pc_sel, pc_en, stall_en, if_rst_n, flush_n};
      ok = ((act & e.mask) == (e.out & e.mask)) && (state == e.st) &&
           (stall_cnt == 32'(e.sc)) && (flush_cnt == 32'(e.fc)) &&
           (!e.chk_imm || (pc_imm == e.imm));
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL vec%0d: got out=%b st=%0d stall=%0d flush=%0d imm=%h, want out=%b/%b st=%0d stall=%0d flush=%0d imm=%h",
                  idx, act, state, stall_cnt, flush_cnt, pc_imm, e.out, e.mask, e.st, e.sc,
                  e.fc, e.imm);
      end
   endtask

   task automatic step(input int idx, input vec_t v);
      halt = v.halt; resume = v.resume; br = v.br; tgt = v.tgt;
      rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; memrd = v.memrd; rdy = v.rdy;
      exp_q.push_back(v);
      @(negedge clk);
      check_vec(idx, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   localparam logic [4:0] F = 5'b11111;
   localparam logic [4:0] P = 5'b11011;  // if_stall_en is left unchecked while pending

   initial begin
      for (int i = 0; i < 4; i++) vt[i] = mk(0,0,0,0, 1,2,0,0,1, 5'b00000,F,0, 1,0, 0,0);
      vt[4]  = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     0,0);
      vt[5]  = mk(0,0,0,0,     1,5,5,1,1, 5'b00010,F,1, 0,0,     0,0);
      vt[6]  = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     1,0);
      vt[7]  = mk(0,0,0,0,     0,0,0,1,1, 5'b01111,F,1, 0,0,     1,0);
      vt[8]  = mk(0,0,1,32'h40,1,2,0,0,1, 5'b11100,F,1, 1,32'h40, 1,0);
      vt[9]  = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     1,1);
      vt[10] = mk(0,0,1,32'h44,7,2,7,1,1, 5'b11100,F,1, 1,32'h44, 1,1);
      vt[11] = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     1,2);
      vt[12] = mk(0,0,0,0,     1,2,0,0,0, 5'b00010,F,1, 0,0,     1,2);
      vt[13] = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     2,2);
      vt[14] = mk(0,0,1,32'h80,1,2,0,0,0, 5'b00100,F,1, 0,0,     2,2);
      for (int i = 15; i < 18; i++) vt[i] = mk(0,0,0,0, 1,2,0,0,0, 5'b00000,P,2, 0,0, 3,2);
      vt[18] = mk(0,0,0,0,     1,2,0,0,1, 5'b11000,P,2, 1,32'h80, 3,2);
      vt[19] = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     3,3);
      vt[20] = mk(1,0,0,0,     1,2,0,0,1, 5'b00000,F,1, 0,0,     3,3);
      vt[21] = mk(0,0,0,0,     1,2,0,0,1, 5'b00010,F,3, 0,0,     4,3);
      vt[22] = mk(0,1,0,0,     1,2,0,0,1, 5'b00010,F,3, 0,0,     4,3);
      vt[23] = mk(0,0,0,0,     1,2,0,0,1, 5'b01111,F,1, 0,0,     4,3);
      vt[24] = mk(0,0,1,32'hC0,1,2,0,0,0, 5'b00100,F,1, 0,0,     4,3);
      vt[25] = mk(0,0,0,0,     1,2,0,0,0, 5'b00000,P,2, 0,0,     5,3);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("reset_state", {pc_sel, pc_en, stall_en, if_rst_n, flush_n, state},
                {5'b00000, 2'd0});
      check_val("reset_imm", pc_imm, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) step(i, vt[i]);

      // Drop reset mid REDIR_PEND, away from any clock edge
      check_val("pend_before_rst", state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_ctrl", {pc_sel, pc_en, stall_en, if_rst_n, flush_n, state},
                {5'b00000, 2'd0});
      check_val("async_rst_cnt", {stall_cnt, flush_cnt}, 0);
      check_val("async_rst_imm", pc_imm, 0);

      // BOOT_CYCLES=1 instance: one boot cycle, then saturating stall counter
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy = 1'b0;
      @(negedge clk);
      check_val("boot1_state", state2, 0);
      @(posedge clk);
      #1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val("sat_state", state2, 1);
      check_val("sat_stall_cnt", stall_cnt2, 2'b11);
      check_val("sat_flush_cnt", flush_cnt2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage and its IF/ID register. It generates the PC hold, PC select/target, IF/ID load-enable and IF/ID flush signals, plus an ID/EX bubble.
- Sources it arbitrates: EX branch redirects, ID load-use hazards, a not-ready instruction memory and halt/resume.
- Holds the PC after reset for a configurable boot window while IMEM initialises.
- Maintains stall and flush performance counters.

Parameters:
BOOT_CYCLES, 4, cycles after reset release during which PC and IF/ID are held (≥1)
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
halt_i  in  1  halt instruction (ecall/ebreak) valid in EX
resume_i  in  1  leave HALT
ex_br_taken_i  in  1  EX resolved taken branch/jump (mispredict redirect)
ex_br_target_i  in  32  redirect target
id_rs1_i  in  5  ID source reg 1
id_rs2_i  in  5  ID source reg 2
ex_rd_i  in  5  EX destination reg
ex_mem_rd_i  in  1  EX instruction is a load
imem_ready_i  in  1  IMEM data for current PC valid this cycle
pc_sel_o  out  1  0: PC+4, 1: pc_imm_o
pc_imm_o  out  32  redirect target to PC mux
pc_en_o  out  1  1: PC register loads
if_stall_en_o  out  1  1: IF/ID loads, 0: IF/ID holds
if_rst_n_o  out  1  0: clear IF/ID (async clear downstream)
id_flush_n_o  out  1  0: ID/EX loads a bubble
stall_cnt_o  out  CNT_W  cycles in RUN with pc_en_o=0
flush_cnt_o  out  CNT_W  redirects taken
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (rst_ni=0, any time, including mid-redirect), asynchronous:
  - state=BOOT, boot counter=0, pending target=0, both perf counters=0.
  - Outputs: pc_en_o=0, if_stall_en_o=0, if_rst_n_o=0, id_flush_n_o=0, pc_sel_o=0, pc_imm_o=0.
- States: BOOT=0, RUN=1, REDIR_PEND=2, HALT=3. All outputs are combinational from state and inputs; only state, counters and pending target are registered.
- BOOT:
  - Outputs: pc_en=0, if_stall_en=0, if_rst_n=0, id_flush_n=0.
  - Boot counter increments each cycle. When it equals BOOT_CYCLES-1, next state is RUN.
  - Net effect: the first PC load occurs in cycle BOOT_CYCLES+1 after reset release.
- RUN: defaults are pc_en=1, if_stall_en=1, if_rst_n=1, id_flush_n=1, pc_sel=0. Conditions are evaluated in priority order; the first match applies:
  1. halt_i: pc_en=0, if_stall_en=0, if_rst_n=0, id_flush_n=0. Next state HALT.
  2. ex_br_taken_i with imem_ready_i=1: pc_sel=1, pc_imm=ex_br_target_i, pc_en=1, if_rst_n=0, id_flush_n=0. flush_cnt increments.
  3. ex_br_taken_i with imem_ready_i=0: latch ex_br_target_i into the pending register. pc_en=0, if_rst_n=0, id_flush_n=0. Next state REDIR_PEND.
  4. Load-use (ex_mem_rd_i=1, ex_rd_i≠0, and ex_rd_i equals id_rs1_i or id_rs2_i): pc_en=0, if_stall_en=0, id_flush_n=0. Exactly one bubble per hazard.
  5. imem_ready_i=0: pc_en=0, if_stall_en=0, id_flush_n=0. Repeats each cycle until ready.
- A load-use hazard and a redirect in the same cycle: the redirect wins and no bubble-stall occurs (the ID instruction is wrong-path).
- REDIR_PEND:
  - While imem_ready_i=0: pc_en=0, if_rst_n=0, id_flush_n=0.
  - When imem_ready_i=1: pc_sel=1, pc_imm=pending target, pc_en=1, if_rst_n=0, id_flush_n=0. flush_cnt increments. Next state RUN.
  - A new ex_br_taken_i here overwrites the pending target.
  - halt_i is ignored (EX holds a bubble).
- HALT:
  - Outputs: pc_en=0, if_stall_en=0, id_flush_n=0, if_rst_n=1.
  - resume_i=1 moves to RUN the next cycle; fetch restarts from the held PC.
- Counters: stall_cnt increments in RUN whenever pc_en_o=0 (cases 1, 3, 4, 5). Both counters saturate at all-ones.
- pc_imm_o outside a redirect cycle equals the pending target register; it is don't-care since pc_sel=0.

Decomposition:
- Package fetch_ctrl_pkg: state enum (2-bit, encodings above), REG_X0 constant 5'd0, NOP/bubble constant 32'h0000_0013 for bench use.
- One natural sub-module: hazard_detect, the combinational load-use comparator. The FSM, boot counter, pending target and perf counters stay in fetch_ctrl.

Test Plan:
- Boot: BOOT_CYCLES=4, release rst_ni.
  - pc_en_o=0 for 4 cycles, then 1 from the 5th; state_o goes 0 to 1.
  - if_rst_n_o=1 and id_flush_n_o=1 once in RUN.
- Load-use: ex_mem_rd_i=1, ex_rd_i=5, id_rs2_i=5, imem_ready_i=1 for one cycle.
  - That cycle: pc_en_o=0, if_stall_en_o=0, id_flush_n_o=0.
  - stall_cnt_o goes 0 to 1.
  - Repeat with ex_rd_i=0: no stall.
- Redirect: ex_br_taken_i=1, target 0x0000_0040, imem_ready_i=1.
  - Same cycle: pc_sel_o=1, pc_imm_o=0x40, pc_en_o=1, if_rst_n_o=0, id_flush_n_o=0.
  - flush_cnt_o=1.
  - Redirect and load-use together: no stall, stall_cnt_o unchanged.
- Pending redirect: target 0x80 while imem_ready_i=0, then ready held low 3 more cycles.
  - state_o=2, pc_en_o=0 for 3 cycles.
  - Ready cycle: pc_sel_o=1, pc_imm_o=0x80, pc_en_o=1; state returns to 1.
- Halt/resume and mid-op reset:
  - halt_i=1: state_o=3, pc_en_o=0. resume_i: RUN the next cycle.
  - rst_ni dropped mid REDIR_PEND: all outputs reach reset values asynchronously; counters=0; state_o=0.
